// File: rtl/ks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ks_pkg
// Description : Shared constants, types and helpers for the Kogge-Stone
//               adder and subtractor family.
// Revision    : 1.0 - initial release
// ============================================================================
package ks_pkg;

    // Operand width used when a block is instantiated without overriding it.
    localparam int KS_NBITS_DEFAULT = 16;

    // Group generate/propagate pair at the default width.
    typedef struct packed {
        logic [KS_NBITS_DEFAULT-1:0] g;
        logic [KS_NBITS_DEFAULT-1:0] p;
    } ks_gp_t;

    // Number of prefix levels needed for n bits, i.e. log2(n).
    // n is expected to be a power of two.
    function automatic int ks_levels(input int n);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < n) begin
            span = span * 2;
            lvl  = lvl + 1;
        end
        return lvl;
    endfunction

endpackage : ks_pkg
`default_nettype wire

// File: rtl/ks_prefix_level.sv
`default_nettype none
// ============================================================================
// Module      : ks_prefix_level
// Description : One Kogge-Stone prefix level. Every bit at or above SPAN
//               merges its group with the group SPAN positions below it;
//               lower bits already hold their full prefix and pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int NBITS = KS_NBITS_DEFAULT,
    parameter int SPAN  = 1
) (
    input  logic [NBITS-1:0] i_g,
    input  logic [NBITS-1:0] i_p,
    output logic [NBITS-1:0] o_g,
    output logic [NBITS-1:0] o_p
);

    // Per-bit black cell (combine) or buffer (pass-through).
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        if (i >= SPAN) begin : g_combine
            assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-SPAN]);
            assign o_p[i] = i_p[i] & i_p[i-SPAN];
        end else begin : g_pass
            assign o_g[i] = i_g[i];
            assign o_p[i] = i_p[i];
        end
    end

endmodule : ks_prefix_level
`default_nettype wire

// File: rtl/kogge_stone_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : kogge_stone_sub_pipe
// Description : Two-stage pipelined Kogge-Stone subtractor computing
//               a - b - borrow_in with borrow-out, signed overflow and zero
//               flags, behind a fully stallable valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module kogge_stone_sub_pipe
    import ks_pkg::*;
#(
    parameter int NBITS = KS_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] diff_out,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    // Level budget: the carry-in fold plus log2(NBITS) span levels. Stage 1
    // takes the first half (rounded up), which includes the fold.
    localparam int c_log2n     = ks_levels(NBITS);
    localparam int c_levels    = c_log2n + 1;
    localparam int c_s1_levels = (c_levels + 1) / 2;
    localparam int c_s1_spans  = c_s1_levels - 1;
    localparam int c_s2_spans  = c_log2n - c_s1_spans;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_adv1;
    logic w_adv2;

    assign w_adv2   = ~r_out_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // ------------------------------------------------------------------
    // Stage 1: bit g/p on a + ~b, carry-in fold, first span levels
    // ------------------------------------------------------------------
    logic             w_cin;
    logic [NBITS-1:0] w_bit_g;
    logic [NBITS-1:0] w_bit_p;
    logic [NBITS-1:0] w_fold_g;
    logic [NBITS-1:0] w_fold_p;
    logic [NBITS-1:0] w_s1_g;
    logic [NBITS-1:0] w_s1_p;

    assign w_cin   = ~borrow_in;
    assign w_bit_g = a & ~b;
    assign w_bit_p = a ^ ~b;

    // Folding the carry-in into bit 0 makes every later group generate a
    // true carry out of that bit; bit 0's propagate is then consumed.
    assign w_fold_g = {w_bit_g[NBITS-1:1], w_bit_g[0] | (w_bit_p[0] & w_cin)};
    assign w_fold_p = {w_bit_p[NBITS-1:1], 1'b0};

    for (genvar k = 0; k < c_s1_spans; k++) begin : g_s1_level
        logic [NBITS-1:0] w_g_in;
        logic [NBITS-1:0] w_p_in;
        logic [NBITS-1:0] w_g;
        logic [NBITS-1:0] w_p;

        if (k == 0) begin : g_first
            assign w_g_in = w_fold_g;
            assign w_p_in = w_fold_p;
        end else begin : g_chain
            assign w_g_in = g_s1_level[k-1].w_g;
            assign w_p_in = g_s1_level[k-1].w_p;
        end

        ks_prefix_level #(
            .NBITS (NBITS),
            .SPAN  (1 << k)
        ) u_level (
            .i_g (w_g_in),
            .i_p (w_p_in),
            .o_g (w_g),
            .o_p (w_p)
        );
    end

    assign w_s1_g = g_s1_level[c_s1_spans-1].w_g;
    assign w_s1_p = g_s1_level[c_s1_spans-1].w_p;

    // Stage-1 pipeline registers
    logic [NBITS-1:0] r_s1_g;
    logic [NBITS-1:0] r_s1_p;
    logic [NBITS-1:0] r_s1_bit_p;
    logic             r_s1_cin;
    logic             r_s1_a_msb;
    logic             r_s1_b_msb;

    // Stage-1 valid: cleared on reset, follows in_valid when advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
        end
    end

    // Stage-1 data: only captured alongside a valid operand pair.
    always_ff @(posedge clk) begin
        if (w_adv1 && in_valid) begin
            r_s1_g     <= w_s1_g;
            r_s1_p     <= w_s1_p;
            r_s1_bit_p <= w_bit_p;
            r_s1_cin   <= w_cin;
            r_s1_a_msb <= a[NBITS-1];
            r_s1_b_msb <= b[NBITS-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: remaining span levels, sum and flags
    // ------------------------------------------------------------------
    logic [NBITS-1:0] w_grp_g;
    logic [NBITS-1:0] w_carry;
    logic [NBITS-1:0] w_diff;
    logic             w_cout;
    logic             w_ovf;
    logic             w_zero;

    for (genvar k = 0; k < c_s2_spans; k++) begin : g_s2_level
        logic [NBITS-1:0] w_g_in;
        logic [NBITS-1:0] w_p_in;
        logic [NBITS-1:0] w_g;
        logic [NBITS-1:0] w_p;

        if (k == 0) begin : g_first
            assign w_g_in = r_s1_g;
            assign w_p_in = r_s1_p;
        end else begin : g_chain
            assign w_g_in = g_s2_level[k-1].w_g;
            assign w_p_in = g_s2_level[k-1].w_p;
        end

        ks_prefix_level #(
            .NBITS (NBITS),
            .SPAN  (1 << (c_s1_spans + k))
        ) u_level (
            .i_g (w_g_in),
            .i_p (w_p_in),
            .o_g (w_g),
            .o_p (w_p)
        );
    end

    assign w_grp_g = g_s2_level[c_s2_spans-1].w_g;

    // Carry into bit i is the prefix generate of bit i-1; bit 0 sees the
    // raw carry-in.
    assign w_carry = {w_grp_g[NBITS-2:0], r_s1_cin};
    assign w_diff  = r_s1_bit_p ^ w_carry;
    assign w_cout  = w_grp_g[NBITS-1];
    assign w_ovf   = (r_s1_a_msb != r_s1_b_msb) & (w_diff[NBITS-1] != r_s1_a_msb);
    assign w_zero  = (w_diff == '0);

    // Output registers
    logic [NBITS-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    // Output valid: cleared on reset, follows stage 1 when advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
        end
    end

    // Output data: zeroed on reset, loaded only with a valid stage-1 result,
    // held otherwise so a stalled result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_diff   <= w_diff;
            r_borrow <= ~w_cout;
            r_ovf    <= w_ovf;
            r_zero   <= w_zero;
        end
    end

    assign out_valid  = r_out_valid;
    assign diff_out   = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;
    assign zero       = r_zero;

endmodule : kogge_stone_sub_pipe
`default_nettype wire

// File: tb/tb_kogge_stone_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_kogge_stone_sub_pipe
// Description : Self-checking bench for kogge_stone_sub_pipe (NBITS=16).
//               Expected results are queued on acceptance and compared in
//               order as results leave the pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kogge_stone_sub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff_out;
    logic        borrow_out;
    logic        overflow;
    logic        zero;

    kogge_stone_sub_pipe #(.NBITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] diff;
        logic        bo;
        logic        ov;
        logic        z;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_on   = 1'b1;

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        exp_t        e;
        logic [16:0] full;
        int          s;
        full   = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        s      = int'($signed(x)) - int'($signed(y)) - int'({31'd0, bi});
        e.diff = full[15:0];
        e.bo   = full[16];
        e.ov   = (s > 32767) || (s < -32768);
        e.z    = (full[15:0] == 16'd0);
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.diff = d;
        e.bo   = bo;
        e.ov   = ov;
        e.z    = z;
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi, input exp_t e);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bi;
        pend      = e;
    endtask

    // Let combinational outputs settle just before the next rising edge.
    task automatic settle();
        #4;
    endtask

    // Score the transfers happening at the coming edge, then advance.
    task automatic fire();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("diff_out",   {16'd0, diff_out},   {16'd0, e.diff});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                chk("overflow",   {31'd0, overflow},   {31'd0, e.ov});
                chk("zero",       {31'd0, zero},       {31'd0, e.z});
                if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 32'd2);
            end
        end
        if (in_valid && in_ready) begin
            e = pend;
            e.acc_cyc = cyc;
            e.chk_lat = lat_on;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        fire();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    // Hard stop in case the sequence itself ever wedges.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        pend      = mk(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_diff",       {16'd0, diff_out},   32'd0);
        chk("rst_borrow",     {31'd0, borrow_out}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow},   32'd0);
        chk("rst_zero",       {31'd0, zero},       32'd0);
        fire();

        // Directed vectors, back to back
        send(16'd8,      16'd3,      1'b0, mk(16'h0005, 1'b0, 1'b0, 1'b0)); tick();
        send(16'd3,      16'd5,      1'b0, mk(16'hFFFE, 1'b1, 1'b0, 1'b0)); tick();
        send(16'd0,      16'd0,      1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0)); tick();
        send(16'h8000,   16'h0001,   1'b0, mk(16'h7FFF, 1'b0, 1'b1, 1'b0)); tick();
        send(16'hF0F0,   16'hF0F0,   1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1)); tick();
        send(16'h7FFF,   16'hFFFF,   1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0)); tick();
        drain();

        // Random back-to-back stream
        for (int i = 0; i < 100; i++) begin
            ra  = 16'($urandom());
            rb  = 16'($urandom());
            rbi = 1'($urandom_range(0, 1));
            send(ra, rb, rbi, model(ra, rb, rbi));
            tick();
        end
        drain();

        // Backpressure: two accepts fill the pipe, the third waits
        lat_on    = 1'b0;
        out_ready = 1'b0;
        send(16'd10, 16'd1, 1'b0, mk(16'd9, 1'b0, 1'b0, 1'b0));
        settle();
        chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
        fire();
        send(16'd20, 16'd2, 1'b0, mk(16'd18, 1'b0, 1'b0, 1'b0));
        settle();
        chk("bp_ready_2", {31'd0, in_ready}, 32'd1);
        fire();
        send(16'd30, 16'd3, 1'b0, mk(16'd27, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready_full", {31'd0, in_ready},  32'd0);
            chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            chk("bp_diff_hold",  {16'd0, diff_out},  32'd9);
            fire();
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        fire();
        in_valid = 1'b0;
        drain();
        lat_on = 1'b1;

        // Reset with both stages full
        out_ready = 1'b0;
        send(16'd50, 16'd5, 1'b0, mk(16'd45, 1'b0, 1'b0, 1'b0)); tick();
        send(16'd60, 16'd6, 1'b0, mk(16'd54, 1'b0, 1'b0, 1'b0)); tick();
        in_valid = 1'b0;
        settle();
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b1;
        fire();
        rst = 1'b0;
        sb.delete();
        settle();
        chk("mrst_out_valid", {31'd0, out_valid},  32'd0);
        chk("mrst_in_ready",  {31'd0, in_ready},   32'd1);
        chk("mrst_diff",      {16'd0, diff_out},   32'd0);
        chk("mrst_borrow",    {31'd0, borrow_out}, 32'd0);
        chk("mrst_overflow",  {31'd0, overflow},   32'd0);
        chk("mrst_zero",      {31'd0, zero},       32'd0);
        fire();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);
            fire();
        end

        // Pipe still works after the mid-operation reset
        send(16'd7, 16'd7, 1'b0, mk(16'd0, 1'b0, 1'b0, 1'b1)); tick();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_kogge_stone_sub_pipe
`default_nettype wire
